// File: rtl/idu0_queue.sv
// idu0_queue: IDU0 decode front-end.
// Each fetched instruction is decoded on the input side. The decoded bundle is
// buffered in a DEPTH-entry circular queue and presented to IDU1 through a
// registered output stage.
// Optional build macro IDU0_QUEUE_BYPASS_EN: when the queue is empty and IDU1
// is not stalled, an accepted instruction goes straight into the output
// register. This gives 1-cycle latency instead of 2.

package idu0_pkg;
    localparam int XLEN      = 32;
    localparam int INSTR_LEN = 32;

    // Control flags from the decode table. The pc flag marks a pc-relative
    // jump offset (J-format immediate).
    typedef struct packed {
        logic legal;
        logic alu;
        logic load;
        logic store;
        logic condbr;
        logic jal;
        logic pc;
        logic imm12;
        logic imm20;
        logic rs1;
        logic rs2;
        logic rd;
    } decode_out_t;

    typedef struct packed {
        logic [XLEN-1:0] instr_tag;
        logic [XLEN-1:0] imm;
        logic            imm_valid;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [4:0]      shamt;
        decode_out_t     ctl;
    } idu0_out_t;

    // Decode table, keyed by the major opcode
    function automatic decode_out_t decode(input logic [6:0] opcode);
        decode_out_t d;
        d = '0;
        case (opcode)
            7'h37: begin d.legal = 1'b1; d.alu = 1'b1; d.imm20 = 1'b1; d.rd = 1'b1; end
            7'h17: begin d.legal = 1'b1; d.alu = 1'b1; d.imm20 = 1'b1; d.rd = 1'b1; end
            7'h6f: begin d.legal = 1'b1; d.jal = 1'b1; d.imm20 = 1'b1; d.pc = 1'b1; d.rd = 1'b1; end
            7'h67: begin d.legal = 1'b1; d.jal = 1'b1; d.imm12 = 1'b1; d.rs1 = 1'b1; d.rd = 1'b1; end
            7'h63: begin d.legal = 1'b1; d.condbr = 1'b1; d.rs1 = 1'b1; d.rs2 = 1'b1; end
            7'h03: begin d.legal = 1'b1; d.load = 1'b1; d.rs1 = 1'b1; d.rd = 1'b1; end
            7'h23: begin d.legal = 1'b1; d.store = 1'b1; d.rs1 = 1'b1; d.rs2 = 1'b1; end
            7'h13: begin d.legal = 1'b1; d.alu = 1'b1; d.imm12 = 1'b1; d.rs1 = 1'b1; d.rd = 1'b1; end
            7'h33: begin d.legal = 1'b1; d.alu = 1'b1; d.rs1 = 1'b1; d.rs2 = 1'b1; d.rd = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction
endpackage

module idu0_queue
    import idu0_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_LEN-1:0] instr,
    input  logic                 instr_valid,
    input  logic [XLEN-1:0]      instr_tag,
    output logic                 instr_ready,
    input  logic                 pipe_stall,
    input  logic                 pipe_flush,
    output idu0_out_t            idu0_out,
    output logic                 idu0_out_valid,
    output logic [CNT_W-1:0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    decode_out_t     decode_out;
    idu0_out_t       dec_bundle;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] s_imm;

    idu0_out_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic push;
    logic push_q;
    logic pop;
    logic bypass;

    assign u_imm = {instr[31:12], 12'h000};
    assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};

    // Input-side decode: register fields, table flags and masked immediate OR
    always_comb begin
        decode_out          = decode(instr[6:0]);
        dec_bundle          = '0;
        dec_bundle.instr_tag = instr_tag;
        dec_bundle.rs1_addr  = instr[19:15];
        dec_bundle.rs2_addr  = instr[24:20];
        dec_bundle.rd_addr   = instr[11:7];
        dec_bundle.shamt     = instr[24:20];
        dec_bundle.ctl       = decode_out;
        dec_bundle.imm       = ({XLEN{decode_out.imm20 & ~decode_out.pc}}     & u_imm)
                             | ({XLEN{decode_out.imm20 &  decode_out.pc}}     & j_imm)
                             | ({XLEN{decode_out.imm12 |  decode_out.load}}   & i_imm)
                             | ({XLEN{decode_out.condbr}}                     & b_imm)
                             | ({XLEN{decode_out.store}}                      & s_imm);
        dec_bundle.imm_valid = (decode_out.imm20 & ~decode_out.jal) | decode_out.imm12
                             | decode_out.load | decode_out.store;
    end

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early
    assign instr_ready = (occupancy != CNT_W'(DEPTH));
    assign push        = instr_valid & instr_ready & ~pipe_flush;
    assign pop         = (occupancy != '0) & ~pipe_stall & ~pipe_flush;

`ifdef IDU0_QUEUE_BYPASS_EN
    assign bypass = push & (occupancy == '0) & ~pipe_stall;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction never touches storage
    assign push_q = push & ~bypass;

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push_q) begin
            mem[wr_ptr] <= dec_bundle;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (pipe_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_q) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_q && !pop) begin
                occupancy <= occupancy + CNT_W'(1);
            end else if (!push_q && pop) begin
                occupancy <= occupancy - CNT_W'(1);
            end
        end
    end

    // Output register: the queue head wins over bypass; it drains to zero when idle and holds under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idu0_out       <= '0;
            idu0_out_valid <= 1'b0;
        end else if (pipe_flush) begin
            idu0_out       <= '0;
            idu0_out_valid <= 1'b0;
        end else if (!pipe_stall) begin
            if (pop) begin
                idu0_out       <= mem[rd_ptr];
                idu0_out_valid <= 1'b1;
            end else if (bypass) begin
                idu0_out       <= dec_bundle;
                idu0_out_valid <= 1'b1;
            end else begin
                idu0_out       <= '0;
                idu0_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_idu0_queue.sv
// Testbench for idu0_queue. A driver process feeds instructions from a
// stimulus queue with valid/ready handling. A reference model built from
// plain queues tracks the accepted-but-not-emitted bundles. A monitor
// compares the DUT outputs against that model on every falling edge.
// Directed scenarios come first, followed by a randomized phase.

module tb_idu0_queue;
    import idu0_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef IDU0_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [31:0]      instr;
    logic             instr_valid;
    logic [31:0]      instr_tag;
    logic             instr_ready;
    logic             pipe_stall = 1'b0;
    logic             pipe_flush = 1'b0;
    idu0_out_t        idu0_out;
    logic             idu0_out_valid;
    logic [CNT_W-1:0] occupancy;

    idu0_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_tag      (instr_tag),
        .instr_ready    (instr_ready),
        .pipe_stall     (pipe_stall),
        .pipe_flush     (pipe_flush),
        .idu0_out       (idu0_out),
        .idu0_out_valid (idu0_out_valid),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] tag;
    } stim_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_edge = 0;
    bit busy = 1'b0;

    stim_t     drv_q[$];
    idu0_out_t mq[$];
    idu0_out_t em_q[$];
    int        em_cyc[$];

    idu0_out_t exp_out = '0;
    logic      exp_vld = 1'b0;
    bit        loaded = 1'b0;
    bit        m_push;
    idu0_out_t m_new;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference decode written directly from the instruction formats
    function automatic idu0_out_t ref_decode(input logic [31:0] i, input logic [31:0] tag);
        idu0_out_t b;
        logic [31:0] imm_u, imm_j, imm_i, imm_b, imm_s;
        b = '0;
        imm_u = {i[31:12], 12'h000};
        imm_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        imm_i = {{20{i[31]}}, i[31:20]};
        imm_b = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
        b.instr_tag = tag;
        b.rs1_addr  = i[19:15];
        b.rs2_addr  = i[24:20];
        b.rd_addr   = i[11:7];
        b.shamt     = i[24:20];
        case (i[6:0])
            7'h37, 7'h17: begin
                b.ctl.legal = 1; b.ctl.alu = 1; b.ctl.imm20 = 1; b.ctl.rd = 1;
                b.imm = imm_u; b.imm_valid = 1;
            end
            7'h6f: begin
                b.ctl.legal = 1; b.ctl.jal = 1; b.ctl.imm20 = 1; b.ctl.pc = 1; b.ctl.rd = 1;
                b.imm = imm_j; b.imm_valid = 0;
            end
            7'h67: begin
                b.ctl.legal = 1; b.ctl.jal = 1; b.ctl.imm12 = 1; b.ctl.rs1 = 1; b.ctl.rd = 1;
                b.imm = imm_i; b.imm_valid = 1;
            end
            7'h63: begin
                b.ctl.legal = 1; b.ctl.condbr = 1; b.ctl.rs1 = 1; b.ctl.rs2 = 1;
                b.imm = imm_b; b.imm_valid = 0;
            end
            7'h03: begin
                b.ctl.legal = 1; b.ctl.load = 1; b.ctl.rs1 = 1; b.ctl.rd = 1;
                b.imm = imm_i; b.imm_valid = 1;
            end
            7'h23: begin
                b.ctl.legal = 1; b.ctl.store = 1; b.ctl.rs1 = 1; b.ctl.rs2 = 1;
                b.imm = imm_s; b.imm_valid = 1;
            end
            7'h13: begin
                b.ctl.legal = 1; b.ctl.alu = 1; b.ctl.imm12 = 1; b.ctl.rs1 = 1; b.ctl.rd = 1;
                b.imm = imm_i; b.imm_valid = 1;
            end
            7'h33: begin
                b.ctl.legal = 1; b.ctl.alu = 1; b.ctl.rs1 = 1; b.ctl.rs2 = 1; b.ctl.rd = 1;
            end
            default: ;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] r;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f};
        r = $urandom();
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    task automatic push_stim(input logic [31:0] i, input logic [31:0] tag);
        stim_t s;
        s.instr = i;
        s.tag   = tag;
        drv_q.push_back(s);
    endtask

    // Driver: present the head stimulus until accepted; a flush consumes it
    initial begin
        stim_t cur;
        cur = '{32'h0, 32'h0};
        instr_valid = 1'b0;
        instr       = '0;
        instr_tag   = '0;
        forever begin
            @(negedge clk);
            if (!busy && drv_q.size() != 0) begin
                cur  = drv_q.pop_front();
                busy = 1'b1;
            end
            instr_valid = busy;
            if (busy) begin
                instr     = cur.instr;
                instr_tag = cur.tag;
            end
            #1;
            if (busy && rst_n && (pipe_flush || instr_ready)) begin
                busy     = 1'b0;
                acc_edge = cyc + 1;
            end
        end
    end

    // Reference model: queue of pending bundles, updated at each rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        loaded = 1'b0;
        if (rst_n) begin
            m_push = instr_valid && !pipe_flush && (mq.size() != DEPTH);
            m_new  = ref_decode(instr, instr_tag);
            if (pipe_flush) begin
                mq.delete();
                exp_out = '0;
                exp_vld = 1'b0;
            end else begin
                if (!pipe_stall) begin
                    if (mq.size() != 0) begin
                        exp_out = mq.pop_front();
                        exp_vld = 1'b1;
                        loaded  = 1'b1;
                    end else if (BYP && m_push) begin
                        exp_out = m_new;
                        exp_vld = 1'b1;
                        loaded  = 1'b1;
                        m_push  = 1'b0;
                    end else begin
                        exp_out = '0;
                        exp_vld = 1'b0;
                    end
                end
                if (m_push) mq.push_back(m_new);
            end
        end
    end

    // Asynchronous reset empties the model immediately
    initial forever begin
        @(negedge rst_n);
        mq.delete();
        exp_out = '0;
        exp_vld = 1'b0;
    end

    // Monitor: compare outputs against the model and log every newly loaded bundle
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("out_valid", 128'(idu0_out_valid), 128'(exp_vld));
            chk("out_bundle", 128'(idu0_out), 128'(exp_out));
            chk("occupancy", 128'(occupancy), 128'(mq.size()));
            chk("instr_ready", 128'(instr_ready), 128'(mq.size() != DEPTH));
            if (loaded && idu0_out_valid) begin
                em_q.push_back(idu0_out);
                em_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_occ(input int n, input string name);
        for (int k = 0; k < 20 && occupancy != CNT_W'(n); k++) begin
            @(negedge clk);
            #2;
        end
        chk(name, 128'(occupancy), 128'(n));
    endtask

    task automatic wait_emit(input int n, input string name);
        for (int k = 0; k < 40 && em_q.size() < n; k++) begin
            @(negedge clk);
            #2;
        end
        chk(name, 128'(em_q.size()), 128'(n));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            if (drv_q.size() == 0 && !busy && occupancy == '0 && !idu0_out_valid) break;
            step();
        end
    endtask

    initial begin
        int lat;
        int c0;
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lat;
        int c0;
        idu0_out_t b;

        #1 rst_n = 1'b0;
        #1;
        chk("reset_valid", 128'(idu0_out_valid), 128'(0));
        chk("reset_out", 128'(idu0_out), 128'(0));
        chk("reset_occ", 128'(occupancy), 128'(0));
        chk("reset_ready", 128'(instr_ready), 128'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single ADDI
        em_q.delete(); em_cyc.delete();
        step();
        push_stim(32'h00500093, 32'h80000000);
        wait_emit(1, "addi_emit");
        if (em_q.size() > 0) begin
            lat = em_cyc[0] - (acc_edge - 1);
            chk("addi_latency", 128'(lat), 128'(BYP ? 1 : 2));
            b = em_q[0];
            chk("addi_rd", 128'(b.rd_addr), 128'(1));
            chk("addi_imm", 128'(b.imm), 128'(32'h00000005));
            chk("addi_imm_valid", 128'(b.imm_valid), 128'(1));
            chk("addi_alu", 128'(b.ctl.alu), 128'(1));
            chk("addi_tag", 128'(b.instr_tag), 128'(32'h80000000));
        end
        wait_idle();

        // Immediate formats
        em_q.delete(); em_cyc.delete();
        step();
        push_stim(32'h12345137, 32'h100);
        push_stim(32'h00000463, 32'h104);
        push_stim(32'h00112223, 32'h108);
        wait_emit(3, "imm_emit");
        if (em_q.size() == 3) begin
            chk("lui_imm", 128'(em_q[0].imm), 128'(32'h12345000));
            chk("lui_imm_valid", 128'(em_q[0].imm_valid), 128'(1));
            chk("beq_imm", 128'(em_q[1].imm), 128'(32'h00000008));
            chk("beq_imm_valid", 128'(em_q[1].imm_valid), 128'(0));
            chk("sw_imm", 128'(em_q[2].imm), 128'(32'h00000004));
            chk("sw_rs1", 128'(em_q[2].rs1_addr), 128'(2));
            chk("sw_rs2", 128'(em_q[2].rs2_addr), 128'(1));
        end
        wait_idle();

        // Fill under stall, then release
        step();
        pipe_stall = 1'b1;
        em_q.delete(); em_cyc.delete();
        for (int k = 0; k < 6; k++) push_stim(rand_instr(), 32'h200 + 32'(4 * k));
        repeat (10) @(negedge clk);
        #2;
        chk("fill_occ", 128'(occupancy), 128'(DEPTH));
        chk("fill_ready", 128'(instr_ready), 128'(0));
        chk("fill_frozen_valid", 128'(idu0_out_valid), 128'(0));
        chk("fill_frozen_out", 128'(idu0_out), 128'(0));
        step();
        pipe_stall = 1'b0;
        wait_emit(6, "fill_emit");
        if (em_q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("fill_order", 128'(em_q[k].instr_tag), 128'(32'h200 + 32'(4 * k)));
                chk("fill_rate", 128'(em_cyc[k] - em_cyc[0]), 128'(k));
            end
        end
        wait_idle();

        // Simultaneous push and pop at occupancy 2
        step();
        pipe_stall = 1'b1;
        em_q.delete(); em_cyc.delete();
        push_stim(32'h00100113, 32'h300);
        push_stim(32'h00200193, 32'h304);
        wait_occ(2, "pp_fill");
        step();
        pipe_stall = 1'b0;
        push_stim(32'h00300213, 32'h308);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("pp_occ", 128'(occupancy), 128'(2));
        chk("pp_emit_count", 128'(em_q.size()), 128'(1));
        if (em_q.size() > 0) chk("pp_emit_tag", 128'(em_q[0].instr_tag), 128'(32'h300));
        wait_emit(3, "pp_drain");
        wait_idle();

        // Flush with occupancy 3 and a valid output, while an input is presented
        step();
        pipe_stall = 1'b1;
        for (int k = 0; k < 4; k++) push_stim(rand_instr(), 32'h400 + 32'(4 * k));
        wait_occ(4, "flush_fill");
        step();
        pipe_stall = 1'b0;
        step();
        chk("pre_flush_occ", 128'(occupancy), 128'(3));
        chk("pre_flush_valid", 128'(idu0_out_valid), 128'(1));
        pipe_flush = 1'b1;
        push_stim(32'h00500093, 32'h4f0);
        step();
        pipe_flush = 1'b0;
        @(negedge clk);
        #2;
        chk("flush_occ", 128'(occupancy), 128'(0));
        chk("flush_valid", 128'(idu0_out_valid), 128'(0));
        chk("flush_out", 128'(idu0_out), 128'(0));
        em_q.delete(); em_cyc.delete();
        step();
        push_stim(32'h00700093, 32'h4f4);
        wait_emit(1, "post_flush_emit");
        if (em_q.size() > 0) chk("post_flush_tag", 128'(em_q[0].instr_tag), 128'(32'h4f4));
        wait_idle();

        // Asynchronous reset mid-stream
        step();
        pipe_stall = 1'b1;
        push_stim(rand_instr(), 32'h500);
        push_stim(rand_instr(), 32'h504);
        wait_occ(2, "areset_fill");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", 128'(idu0_out_valid), 128'(0));
        chk("areset_out", 128'(idu0_out), 128'(0));
        chk("areset_occ", 128'(occupancy), 128'(0));
        chk("areset_ready", 128'(instr_ready), 128'(1));
        step();
        step();
        rst_n = 1'b1;
        pipe_stall = 1'b0;
        c0 = cyc;
        em_q.delete(); em_cyc.delete();
        push_stim(32'h00900093, 32'h508);
        wait_emit(1, "post_reset_emit");
        chk("post_reset_accept_edge", 128'(acc_edge), 128'(c0 + 1));
        if (em_q.size() > 0) chk("post_reset_tag", 128'(em_q[0].instr_tag), 128'(32'h508));
        wait_idle();

        // Randomized traffic with stalls and occasional flushes
        for (int k = 0; k < 400; k++) begin
            step();
            pipe_stall = ($urandom_range(0, 99) < 30);
            pipe_flush = ($urandom_range(0, 99) < 5);
            if (drv_q.size() < 3 && $urandom_range(0, 1) == 1)
                push_stim(rand_instr(), 32'h1000 + 32'(4 * k));
        end
        step();
        pipe_stall = 1'b0;
        pipe_flush = 1'b0;
        wait_idle();
        @(negedge clk);
        #2;
        chk("final_occ", 128'(occupancy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
